// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu - load/store unit behind the EX stage.
//
// Takes the effective address, the forwarded store data and funct3 of a
// memory instruction. It runs one data-memory transaction over a
// req/gnt/rvalid handshake and returns an aligned, extended load result.
// The pipeline is stalled while a transaction is in flight.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | no transaction; ex_ready=1, can accept a load/store
// S_REQ  | dmem_req held high with stable addr/we/wdata until dmem_gnt
// S_WAIT | load granted, waiting for dmem_rvalid
//
// Ports
//   clk, rst_n                  core clock, async active-low reset
//   ex_valid, ctrl_mem_rd/wr    instruction from EX (store wins over load)
//   mem_func, addr, data_rs2    funct3, effective address, store data
//   rd_idx                      load destination register
//   ex_ready, stall             idle / transaction-in-flight indicators
//   dmem_req/we/addr/wdata      data-memory request side
//   dmem_gnt/rvalid/rdata       data-memory response side
//   wb_valid/rd/data            one-cycle load writeback
//   ma_fault, ma_addr           one-cycle misaligned-access report
// ---------------------------------------------------------------------------
module lsu #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ctrl_mem_rd,
    input  logic              ctrl_mem_wr,
    input  logic [2:0]        mem_func,
    input  logic [DWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] data_rs2,
    input  logic [4:0]        rd_idx,
    output logic              ex_ready,
    output logic              stall,
    output logic              dmem_req,
    output logic [3:0]        dmem_we,
    output logic [DWIDTH-1:0] dmem_addr,
    output logic [DWIDTH-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DWIDTH-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [DWIDTH-1:0] wb_data,
    output logic              ma_fault,
    output logic [DWIDTH-1:0] ma_addr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;

    logic              is_load_q;
    logic [2:0]        func_q;
    logic [1:0]        lsb_q;
    logic [4:0]        rd_q;

    logic              accept;
    logic              misaligned;
    logic              sz_byte;
    logic              sz_half;
    logic [3:0]        st_we;
    logic [DWIDTH-1:0] st_wdata;
    logic [DWIDTH-1:0] rdata_sh;
    logic [DWIDTH-1:0] ld_result;

    // funct3[1:0]=00 byte, 01 half; 10 and the undefined encodings are word.
    assign sz_byte = (mem_func[1:0] == 2'b00);
    assign sz_half = (mem_func[1:0] == 2'b01);

    always_comb begin
        misaligned = 1'b0;
        st_we      = 4'b1111;
        st_wdata   = data_rs2;
        if (sz_byte) begin
            st_we    = 4'b0001 << addr[1:0];
            st_wdata = {4{data_rs2[7:0]}};
        end else if (sz_half) begin
            misaligned = addr[0];
            st_we      = 4'b0011 << {addr[1], 1'b0};
            st_wdata   = {2{data_rs2[15:0]}};
        end else begin
            misaligned = (addr[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ex_valid && (ctrl_mem_rd || ctrl_mem_wr)) begin
                    accept = 1'b1;
                    if (!misaligned) begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (dmem_gnt) begin
                    state_d = is_load_q ? S_WAIT : S_IDLE;
                end
            end
            S_WAIT: begin
                if (dmem_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ex_ready = (state_q == S_IDLE);
    assign stall    = (state_q != S_IDLE);
    assign dmem_req = (state_q == S_REQ);

    // Bring the addressed byte/half down to bit 0, then extend.
    assign rdata_sh = dmem_rdata >> {lsb_q, 3'b000};

    always_comb begin
        ld_result = dmem_rdata;
        case (func_q)
            3'b000:  ld_result = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            3'b001:  ld_result = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            3'b100:  ld_result = {24'd0, rdata_sh[7:0]};
            3'b101:  ld_result = {16'd0, rdata_sh[15:0]};
            default: ld_result = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_load_q  <= 1'b0;
            func_q     <= 3'd0;
            lsb_q      <= 2'd0;
            rd_q       <= 5'd0;
            dmem_we    <= 4'd0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= '0;
            ma_fault   <= 1'b0;
            ma_addr    <= '0;
        end else begin
            wb_valid <= 1'b0;
            ma_fault <= 1'b0;

            if (accept) begin
                if (misaligned) begin
                    ma_fault <= 1'b1;
                    ma_addr  <= addr;
                end else begin
                    // A store wins when both control bits are set.
                    is_load_q  <= !ctrl_mem_wr;
                    func_q     <= mem_func;
                    lsb_q      <= addr[1:0];
                    rd_q       <= rd_idx;
                    dmem_addr  <= {addr[DWIDTH-1:2], 2'b00};
                    dmem_we    <= ctrl_mem_wr ? st_we : 4'b0000;
                    dmem_wdata <= st_wdata;
                end
            end

            if (state_q == S_WAIT && dmem_rvalid) begin
                wb_valid <= 1'b1;
                wb_rd    <= rd_q;
                wb_data  <= ld_result;
            end
        end
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the EX stage in the RISC-V core. It takes the ALU result as the effective address, the forwarded rs2 value as store data, and the funct3 of the memory instruction. It runs one data-memory transaction over a request/grant/rvalid handshake, then returns an aligned, sign- or zero-extended load result to writeback. It stalls the pipeline while a transaction is in flight.

## Interface
- DWIDTH, 32, data/address width; only 32 is supported because the byte-lane logic is fixed.
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX presents an instruction this cycle.
- ctrl_mem_rd  in  1  instruction is a load.
- ctrl_mem_wr  in  1  instruction is a store; wins if both this and ctrl_mem_rd are set.
- mem_func  in  3  funct3: LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010.
- addr  in  DWIDTH  effective address (EX alu_out).
- data_rs2  in  DWIDTH  store data, already forwarded.
- rd_idx  in  5  load destination register.
- ex_ready  out  1  LSU idle and able to accept.
- stall  out  1  transaction in flight; upstream stages hold.
- dmem_req  out  1  memory request.
- dmem_we  out  4  byte write enables; 0 means read.
- dmem_addr  out  DWIDTH  word-aligned address; bits [1:0] are always 0.
- dmem_wdata  out  DWIDTH  lane-replicated store data.
- dmem_gnt  in  1  memory accepts the request this cycle.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  DWIDTH  read word.
- wb_valid  out  1  one-cycle pulse: load result ready.
- wb_rd  out  5  destination of the result.
- wb_data  out  DWIDTH  extended load result.
- ma_fault  out  1  one-cycle pulse: misaligned access.
- ma_addr  out  DWIDTH  faulting address.

## Operation
- FSM has three states: IDLE, REQ, WAIT.
  - ex_ready = (state==IDLE).
  - stall = (state!=IDLE).
- Acceptance: in IDLE, when ex_valid & (ctrl_mem_rd | ctrl_mem_wr).
  - The LSU registers type, mem_func, addr[1:0], rd_idx, dmem_addr={addr[31:2],2'b00}, dmem_we and dmem_wdata.
  - With neither ctrl bit set, nothing happens.
- Misalignment check, done at acceptance:
  - H/HU/SH faults when addr[0]=1.
  - W/SW faults when addr[1:0]!=0.
  - On a fault: no request is issued, the state stays IDLE, and next cycle ma_fault=1 with ma_addr=addr.
- Undefined funct3 values (011, 110, 111) are treated as a word access.
- Store lane generation:
  - SB: wdata={4{rs2[7:0]}}, we=4'b0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, we=4'b0011<<{addr[1],1'b0}.
  - SW: wdata=rs2, we=4'b1111.
  - Loads: we=0.
- IDLE→REQ on a non-faulting acceptance. dmem_req=1 in REQ. dmem_addr, dmem_we and dmem_wdata are held stable until dmem_gnt.
- REQ with dmem_gnt:
  - a store goes to IDLE;
  - a load goes to WAIT.
- WAIT with dmem_rvalid:
  - select the byte or half at rdata>>(8*addr[1:0]);
  - sign-extend (LB/LH) or zero-extend (LBU/LHU); LW passes the word through;
  - register the result into wb_data, set wb_rd, pulse wb_valid for one cycle, and go to IDLE.
- dmem_rvalid is ignored outside WAIT. dmem_gnt is ignored outside REQ.
- A load with rd_idx=0 still performs the access and pulses wb_valid with wb_rd=0.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE;
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0;
  - wb_valid=0, wb_rd=0, wb_data=0;
  - ma_fault=0, ma_addr=0.
- Reset mid-transaction drops the transaction. An rvalid arriving after release is ignored.
- Store accepted in cycle T, grant in T+1: dmem_req is high in T+1 and ex_ready is high in T+2.
- Load accepted in T, grant in T+1, rvalid in T+2: wb_valid is high in T+3 and ex_ready is high in T+3.
- dmem_rvalid in the same cycle as dmem_gnt is not allowed; the earliest legal rvalid is the cycle after gnt.
- Each extra cycle of delayed gnt or rvalid adds one cycle of stall. There is no timeout.
- Back-to-back operations: a new acceptance is possible in the cycle the FSM is back in IDLE, including the cycle wb_valid pulses.
- ma_fault pulses in T+1 for a faulting acceptance in T. The LSU can accept again in T+1.

## Test plan
- SW: addr=0x104, rs2=0xDEADBEEF, gnt immediate → dmem_addr=0x104, we=1111, wdata=0xDEADBEEF; ex_ready is back two cycles after acceptance.
- SB: addr=0x103, rs2=0x000000A5 → we=1000, wdata=0xA5A5A5A5.
- LB then LBU: addr=0x202, rdata=0x12F45678 → wb_data=0xFFFFFFF4 for LB and 0x000000F4 for LBU, wb_rd correct, wb_valid held for exactly one cycle.
- LH: addr=0x302, gnt delayed 3 cycles, rvalid delayed 2 more → wb_data=0xFFFF8001 for rdata=0x80011234; stall stays high every cycle until writeback.
- LW at addr=0x401 → no dmem_req; ma_fault pulses with ma_addr=0x401. SH at 0x403 → same behaviour.
- rst_n dropped while in WAIT → all outputs go to reset values immediately; an rvalid after release produces no wb_valid.
